multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Multicycle sequencer for the Feather ARM-subset datapath. It replaces single-cycle control when fetch, decode, execute, memory and writeback share one ALU and one memory port across several cycles.
- A Moore FSM that drives IR/PC write enables, datapath mux selects, ALU control, register and memory write enables.
- Holds the architectural NZCV flags register and evaluates the condition field.

Parameters:
- none (instruction encoding is fixed by the ISA subset)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset_i  in  1  synchronous, active-high reset
- instruction_i  in  32  contents of the instruction register (valid from DECODE onward)
- alu_nzcv_i  in  4  combinational ALU flags {N,Z,C,V}
- state_o  out  4  current FSM state (debug/verification)
- ir_write_o  out  1  latch fetched word into instruction register
- pc_write_o  out  1  write result/ALU output into PC
- adr_src_o  out  1  memory address select: 0=PC, 1=ALU result register
- mem_write_o  out  1  data memory write enable
- reg_write_o  out  1  register file write enable (Rd = instruction_i[15:12])
- alu_src_a_o  out  2  00=Rn, 01=PC
- alu_src_b_o  out  2  00=shifted Rm, 01=immediate (rotated imm8 for DP, imm12 for mem), 10=constant 4, 11=sign-extended imm24<<2
- alu_control_o  out  4  ALU opcode; 4'b0100=ADD, 4'b0010=SUB
- result_src_o  out  2  00=ALU result register, 01=memory data register, 10=ALU output direct
- flags_o  out  4  architectural NZCV register
- instr_retired_o  out  1  one-cycle pulse on final cycle of every instruction, including condition-failed instructions

Behaviour:
- Reset: on any rising edge with reset_i=1, state goes to FETCH, flags_o=0, and every output is 0 during the reset cycle. This applies mid-instruction: pending writes are abandoned with no partial side effects.
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9. Codes 10-15 go to FETCH.
- FETCH:
  - adr_src=0, ir_write=1, alu_src_a=01, alu_src_b=10, alu_control=ADD, result_src=10, pc_write=1.
  - Next state: DECODE.
- DECODE:
  - Evaluates cond = instruction_i[31:28] against flags_o: EQ NE CS CC MI PL VS VC HI LS GE LT GT LE AL; 1111 = never.
  - Cond fail or op[27:26]=11: instr_retired=1, next state FETCH, no writes.
  - op=00: next EXECI if bit25=1, else EXECR.
  - op=01: next MEMADR.
  - op=10: next BRANCH.
- EXECR / EXECI:
  - alu_src_a=00; alu_src_b=00 (EXECR) or 01 (EXECI); alu_control=instruction_i[24:21].
  - If S (bit 20) is set, or funct[24:23]=2'b10 (TST/TEQ/CMP/CMN), flags_o <= alu_nzcv_i at the end of the cycle.
  - Compare group: instr_retired=1, next FETCH.
  - Otherwise: next ALUWB.
- ALUWB:
  - result_src=00, instr_retired=1.
  - Rd≠15: reg_write=1. Rd=15: pc_write=1, reg_write=0.
  - Next state: FETCH.
- MEMADR:
  - alu_src_a=00, alu_src_b=01; alu_control=ADD if U (bit 23)=1, else SUB.
  - Next state: MEMRD if L (bit 20)=1, else MEMWR.
- MEMRD: adr_src=1; next MEMWB.
- MEMWB: result_src=01, instr_retired=1; reg_write/pc_write by Rd exactly as in ALUWB; next FETCH.
- MEMWR: adr_src=1, mem_write=1, instr_retired=1; next FETCH.
- BRANCH:
  - alu_src_a=01, alu_src_b=11, alu_control=ADD, result_src=10, pc_write=1, instr_retired=1.
  - Link bit 24 is ignored (BL unsupported).
  - Next state: FETCH.
- Outputs not listed for a state are 0.
- Flags change only in EXECR/EXECI.
- Latency without wait states, in cycles: DP=4, compare=3, LDR=5, STR=4, B=3, condition-fail/undefined=2.

Optional Feature:
- Macro: FEATHER_MEM_WAIT_EN.
- When defined:
  - Adds input port mem_ready_i (1 bit).
  - FETCH, MEMRD and MEMWR hold while mem_ready_i=0.
  - In FETCH: ir_write and pc_write are asserted only in the cycle with mem_ready_i=1.
  - In MEMWR: mem_write stays high throughout the wait; instr_retired fires only on the ready cycle.
- When undefined: the port is absent and each memory state lasts exactly 1 cycle.

Test Plan:
- Reset, then ADDS R1,R1,R2 (0xE0911002) with alu_nzcv_i=1000 in EXECR -> states 0,1,6,8; flags_o=1000 after EXECR; reg_write=1 only in ALUWB; instr_retired pulses once.
- CMP R0,#0 (0xE3500000) with alu_nzcv_i=0110 -> states 0,1,7,0; flags_o=0110; reg_write never asserted.
- BEQ (0x0A000002): with flags Z=1 -> states 0,1,9 and pc_write in BRANCH with alu_src_b=11; with Z=0 -> states 0,1,0 and pc_write only in FETCH.
- LDR R3,[R4,#8] (0xE5943008) -> states 0,1,2,3,4; alu_control=0100 in MEMADR, adr_src=1 in MEMRD, result_src=01 and reg_write=1 in MEMWB. STR R3,[R4,#-4] (0xE5043004) -> alu_control=0010, mem_write=1 in MEMWR.
- Assert reset_i during MEMWR of a STR -> next state FETCH, mem_write_o=0 in the reset cycle, flags_o=0.
- With FEATHER_MEM_WAIT_EN: hold mem_ready_i=0 for 3 cycles in FETCH -> state stays 0 and ir_write=0; ir_write=1 exactly on the ready cycle.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Control/status bundle between the Feather multicycle sequencer (master) and its datapath (slave).
// Optional macro FEATHER_MEM_WAIT_EN adds the mem_ready_i memory handshake.
interface multicycle_control_if;
    logic [31:0] instruction_i;
    logic [3:0]  alu_nzcv_i;
`ifdef FEATHER_MEM_WAIT_EN
    logic        mem_ready_i;
`endif
    logic [3:0]  state_o;
    logic        ir_write_o;
    logic        pc_write_o;
    logic        adr_src_o;
    logic        mem_write_o;
    logic        reg_write_o;
    logic [1:0]  alu_src_a_o;
    logic [1:0]  alu_src_b_o;
    logic [3:0]  alu_control_o;
    logic [1:0]  result_src_o;
    logic [3:0]  flags_o;
    logic        instr_retired_o;

`ifdef FEATHER_MEM_WAIT_EN
    modport master (
        input  instruction_i, alu_nzcv_i, mem_ready_i,
        output state_o, ir_write_o, pc_write_o, adr_src_o, mem_write_o, reg_write_o,
               alu_src_a_o, alu_src_b_o, alu_control_o, result_src_o, flags_o, instr_retired_o
    );
    modport slave (
        output instruction_i, alu_nzcv_i, mem_ready_i,
        input  state_o, ir_write_o, pc_write_o, adr_src_o, mem_write_o, reg_write_o,
               alu_src_a_o, alu_src_b_o, alu_control_o, result_src_o, flags_o, instr_retired_o
    );
`else
    modport master (
        input  instruction_i, alu_nzcv_i,
        output state_o, ir_write_o, pc_write_o, adr_src_o, mem_write_o, reg_write_o,
               alu_src_a_o, alu_src_b_o, alu_control_o, result_src_o, flags_o, instr_retired_o
    );
    modport slave (
        output instruction_i, alu_nzcv_i,
        input  state_o, ir_write_o, pc_write_o, adr_src_o, mem_write_o, reg_write_o,
               alu_src_a_o, alu_src_b_o, alu_control_o, result_src_o, flags_o, instr_retired_o
    );
`endif
endinterface

// File: rtl/multicycle_control.sv
// Multicycle sequencer for the Feather ARM-subset datapath, holding the NZCV flags register.
// Optional macro FEATHER_MEM_WAIT_EN stretches FETCH/MEMRD/MEMWR until mem_ready_i is high.
module multicycle_control (
    input  logic                 clk,
    input  logic                 reset_i,
    multicycle_control_if.master bus
);
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
    } state_t;

    typedef struct packed {
        logic       ir_write;
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_control;
        logic [1:0] result_src;
        logic       instr_retired;
    } ctrl_t;

    localparam logic [3:0] ALU_ADD = 4'b0100;
    localparam logic [3:0] ALU_SUB = 4'b0010;

    state_t      state_q, state_d;
    ctrl_t       ctrl_q, ctrl_d;
    logic [3:0]  flags_q, flags_d;
    logic [31:0] instr;
    logic        mem_ready;
    logic        cond_ok;
    logic        is_compare;
    logic        decode_retire;
    logic        wait_gate;
    logic        out_en;
    logic        unused_instr_bits;

    assign instr = bus.instruction_i;
    assign unused_instr_bits = ^{instr[22], instr[19:16], instr[11:0]};

`ifdef FEATHER_MEM_WAIT_EN
    assign mem_ready = bus.mem_ready_i;
`else
    assign mem_ready = 1'b1;
`endif

    function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        {n, z, c, v} = nzcv;
        case (cond)
            4'h0:    return z;
            4'h1:    return !z;
            4'h2:    return c;
            4'h3:    return !c;
            4'h4:    return n;
            4'h5:    return !n;
            4'h6:    return v;
            4'h7:    return !v;
            4'h8:    return c && !z;
            4'h9:    return !c || z;
            4'hA:    return n == v;
            4'hB:    return n != v;
            4'hC:    return !z && (n == v);
            4'hD:    return z || (n != v);
            4'hE:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Control word a state presents for its whole duration; instruction bits are stable from DECODE on.
    function automatic ctrl_t ctrl_for(input state_t s, input logic [31:0] ins);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.ir_write    = 1'b1;
                c.pc_write    = 1'b1;
                c.alu_src_a   = 2'b01;
                c.alu_src_b   = 2'b10;
                c.alu_control = ALU_ADD;
                c.result_src  = 2'b10;
            end
            EXECR, EXECI: begin
                c.alu_src_b     = (s == EXECI) ? 2'b01 : 2'b00;
                c.alu_control   = ins[24:21];
                c.instr_retired = (ins[24:23] == 2'b10);
            end
            ALUWB, MEMWB: begin
                c.result_src    = (s == MEMWB) ? 2'b01 : 2'b00;
                c.instr_retired = 1'b1;
                c.reg_write     = (ins[15:12] != 4'd15);
                c.pc_write      = (ins[15:12] == 4'd15);
            end
            MEMADR: begin
                c.alu_src_b   = 2'b01;
                c.alu_control = ins[23] ? ALU_ADD : ALU_SUB;
            end
            MEMRD: begin
                c.adr_src = 1'b1;
            end
            MEMWR: begin
                c.adr_src       = 1'b1;
                c.mem_write     = 1'b1;
                c.instr_retired = 1'b1;
            end
            BRANCH: begin
                c.alu_src_a     = 2'b01;
                c.alu_src_b     = 2'b11;
                c.alu_control   = ALU_ADD;
                c.result_src    = 2'b10;
                c.pc_write      = 1'b1;
                c.instr_retired = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    assign cond_ok       = cond_holds(instr[31:28], flags_q);
    assign is_compare    = (instr[24:23] == 2'b10);
    assign decode_retire = (state_q == DECODE) && (!cond_ok || (instr[27:26] == 2'b11));

    always_comb begin
        state_d = FETCH;
        flags_d = flags_q;
        case (state_q)
            FETCH:  state_d = mem_ready ? DECODE : FETCH;
            DECODE: begin
                if (!cond_ok) begin
                    state_d = FETCH;
                end else begin
                    case (instr[27:26])
                        2'b00:   state_d = instr[25] ? EXECI : EXECR;
                        2'b01:   state_d = MEMADR;
                        2'b10:   state_d = BRANCH;
                        default: state_d = FETCH;
                    endcase
                end
            end
            EXECR, EXECI: begin
                if (instr[20] || is_compare) begin
                    flags_d = bus.alu_nzcv_i;
                end
                state_d = is_compare ? FETCH : ALUWB;
            end
            MEMADR: state_d = instr[20] ? MEMRD : MEMWR;
            MEMRD:  state_d = mem_ready ? MEMWB : MEMRD;
            MEMWR:  state_d = mem_ready ? FETCH : MEMWR;
            default: state_d = FETCH;
        endcase
        ctrl_d = ctrl_for(state_d, instr);
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            state_q <= FETCH;
            flags_q <= 4'd0;
            ctrl_q  <= ctrl_for(FETCH, 32'd0);
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // Writes that complete a memory access are held back until the memory accepts it.
    assign wait_gate = mem_ready || !((state_q == FETCH) || (state_q == MEMWR));
    assign out_en    = !reset_i;

    assign bus.state_o         = out_en ? state_q : 4'd0;
    assign bus.flags_o         = out_en ? flags_q : 4'd0;
    assign bus.ir_write_o      = out_en && wait_gate && ctrl_q.ir_write;
    assign bus.pc_write_o      = out_en && wait_gate && ctrl_q.pc_write;
    assign bus.adr_src_o       = out_en && ctrl_q.adr_src;
    assign bus.mem_write_o     = out_en && ctrl_q.mem_write;
    assign bus.reg_write_o     = out_en && ctrl_q.reg_write;
    assign bus.alu_src_a_o     = out_en ? ctrl_q.alu_src_a : 2'b00;
    assign bus.alu_src_b_o     = out_en ? ctrl_q.alu_src_b : 2'b00;
    assign bus.alu_control_o   = out_en ? ctrl_q.alu_control : 4'd0;
    assign bus.result_src_o    = out_en ? ctrl_q.result_src : 2'b00;
    assign bus.instr_retired_o = out_en && ((wait_gate && ctrl_q.instr_retired) || decode_retire);

endmodule
